// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared types and constants for the PWM waveform engine.
//   pwm_state_t      : engine state (IDLE / RUN / DRAIN)
//   ENABLE_BIT       : control-register bit carrying the run request
//   POLARITY_BIT     : control-register bit selecting active-low output
//   *_W_DEF          : default widths for counter, prescaler and dead-time
package pwm_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    localparam int ENABLE_BIT   = 0;
    localparam int POLARITY_BIT = 1;

    localparam int CNT_W_DEF = 16;
    localparam int PRE_W_DEF = 8;
    localparam int DT_W_DEF  = 8;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: tick divider for the PWM engine.
//   clk    in   : clock, rising edge
//   rst_n  in   : synchronous active-low reset
//   clear  in   : hold the counter at 0 (engine idle)
//   en     in   : count enable
//   limit  in   : terminal count S; one tick every S+1 enabled cycles
//   tick   out  : high in the cycle the counter sits at limit
module pwm_prescaler
    import pwm_gen_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [PRE_W-1:0] limit,
    output logic             tick
);

    logic [PRE_W-1:0] count;

    assign tick = en && (count == limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + PRE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_gen_core.sv
// pwm_gen_core: PWM waveform engine fed by the AXI4-Lite register slave.
//   ACLK, ARESETN         : clock, synchronous active-low reset
//   cfg_enable            : run request
//   cfg_polarity          : 0 active-high, 1 active-low (not shadowed)
//   cfg_period/duty       : terminal count P and active ticks D
//   cfg_prescale          : tick divider S
//   cfg_load              : write strobe; shadows reload at the next wrap
//   pwm_out               : registered PWM pin
//   cycle_tick            : one-cycle pulse when the counter wraps to 0
//   busy                  : high in RUN and DRAIN
//   cnt_value             : current period counter
// Optional macro PWM_DEADTIME_EN adds parameter DT_W, input cfg_deadtime and
// output pwm_out_n (complementary pin with rising-edge dead time).
module pwm_gen_core
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W  = DT_W_DEF
`endif
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic             cfg_polarity,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [PRE_W-1:0] cfg_prescale,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]  cfg_deadtime,
    output logic             pwm_out_n,
`endif
    input  logic             cfg_load,
    output logic             pwm_out,
    output logic             cycle_tick,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_value
);

    pwm_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh;
    logic [PRE_W-1:0] prescale_sh;
    logic             pending;
    logic             running;
    logic             tick;
    logic             wrap;
    logic             active;
    logic             reload;
    logic             hi_lvl;

    assign running   = (state != IDLE);
    assign wrap      = tick && (cnt == period_sh);
    assign active    = (cnt < duty_sh);
    // A write landing in the wrap cycle itself is taken at this wrap.
    assign reload    = wrap && (pending || cfg_load);
    assign busy      = running;
    assign cnt_value = cnt;

    pwm_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clear (!running),
        .en    (running),
        .limit (prescale_sh),
        .tick  (tick)
    );

`ifdef PWM_DEADTIME_EN
    // run_len counts consecutive cycles (including this one) that 'active'
    // has held its value; a side may only assert once run_len exceeds the
    // dead time, which delays every rising edge by cfg_deadtime cycles.
    logic [DT_W:0] len_q;
    logic [DT_W:0] run_len;
    logic          act_q;
    logic          gap_ok;
    logic          lo_lvl;

    always_comb begin
        run_len = (DT_W+1)'(1);
        if (active == act_q) begin
            run_len = (len_q == '1) ? len_q : len_q + (DT_W+1)'(1);
        end
    end

    assign gap_ok = (run_len > {1'b0, cfg_deadtime});
    assign hi_lvl = active && gap_ok;
    assign lo_lvl = !active && gap_ok;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            len_q     <= '0;
            act_q     <= 1'b0;
            pwm_out_n <= 1'b0;
        end else if (state == IDLE) begin
            len_q     <= '0;
            act_q     <= 1'b0;
            pwm_out_n <= cfg_polarity;
        end else begin
            len_q     <= run_len;
            act_q     <= active;
            pwm_out_n <= lo_lvl ^ cfg_polarity;
        end
    end
`else
    assign hi_lvl = active;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_enable) state_nxt = RUN;
            RUN:     if (!cfg_enable) state_nxt = DRAIN;
            DRAIN: begin
                if (cfg_enable) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt         <= '0;
            period_sh   <= '0;
            duty_sh     <= '0;
            prescale_sh <= '0;
            pending     <= 1'b0;
            pwm_out     <= 1'b0;
            cycle_tick  <= 1'b0;
        end else if (state == IDLE) begin
            cnt        <= '0;
            pending    <= 1'b0;
            cycle_tick <= 1'b0;
            pwm_out    <= cfg_polarity;
            if (cfg_enable) begin
                period_sh   <= cfg_period;
                duty_sh     <= cfg_duty;
                prescale_sh <= cfg_prescale;
            end
        end else begin
            cycle_tick <= wrap;
            pwm_out    <= hi_lvl ^ cfg_polarity;
            if (tick) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            if (reload) begin
                period_sh   <= cfg_period;
                duty_sh     <= cfg_duty;
                prescale_sh <= cfg_prescale;
            end
            if (wrap) begin
                pending <= 1'b0;
            end else if (cfg_load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen_core.sv
// tb_pwm_gen_core: directed self-checking bench for pwm_gen_core.
module tb_pwm_gen_core;

    logic        ACLK;
    logic        ARESETN;
    logic        cfg_enable;
    logic        cfg_polarity;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic [7:0]  cfg_prescale;
    logic        cfg_load;
    logic        pwm_out;
    logic        cycle_tick;
    logic        busy;
    logic [15:0] cnt_value;
`ifdef PWM_DEADTIME_EN
    logic [7:0]  cfg_deadtime;
    logic        pwm_out_n;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] pw_bits;
    logic [63:0] ct_bits;
    logic [63:0] bz_bits;
    logic [63:0] pn_bits;
    logic [15:0] cnt_log [64];

    pwm_gen_core #(
        .CNT_W (16),
        .PRE_W (8)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_polarity (cfg_polarity),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_prescale (cfg_prescale),
`ifdef PWM_DEADTIME_EN
        .cfg_deadtime (cfg_deadtime),
        .pwm_out_n    (pwm_out_n),
`endif
        .cfg_load     (cfg_load),
        .pwm_out      (pwm_out),
        .cycle_tick   (cycle_tick),
        .busy         (busy),
        .cnt_value    (cnt_value)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic capture(input int n);
        pw_bits = '0;
        ct_bits = '0;
        bz_bits = '0;
        pn_bits = '0;
        for (int i = 0; i < n; i++) begin
            cyc();
            pw_bits[i] = pwm_out;
            ct_bits[i] = cycle_tick;
            bz_bits[i] = busy;
            cnt_log[i] = cnt_value;
`ifdef PWM_DEADTIME_EN
            pn_bits[i] = pwm_out_n;
`endif
        end
    endtask

    // Reset, program, and sample enable at the next edge: RUN with cnt=0.
    task automatic start(input int s, input int p, input int d, input logic pol);
        ARESETN    = 1'b0;
        cfg_enable = 1'b0;
        cyc();
        ARESETN      = 1'b1;
        cfg_prescale = 8'(s);
        cfg_period   = 16'(p);
        cfg_duty     = 16'(d);
        cfg_polarity = pol;
        cfg_enable   = 1'b1;
        cyc();
    endtask

    initial begin
        ARESETN      = 1'b0;
        cfg_enable   = 1'b0;
        cfg_polarity = 1'b0;
        cfg_period   = '0;
        cfg_duty     = '0;
        cfg_prescale = '0;
        cfg_load     = 1'b0;
`ifdef PWM_DEADTIME_EN
        cfg_deadtime = '0;
`endif
        cyc();
        cyc();
        check("rst_pwm",  64'(pwm_out),    64'h0);
        check("rst_tick", 64'(cycle_tick), 64'h0);
        check("rst_busy", 64'(busy),       64'h0);
        check("rst_cnt",  64'(cnt_value),  64'h0);
`ifdef PWM_DEADTIME_EN
        check("rst_pwm_n", 64'(pwm_out_n), 64'h0);
`endif

        // Basic waveform S=0 P=9 D=3
        start(0, 9, 3, 1'b0);
        check("t1_busy", 64'(busy),      64'h1);
        check("t1_cnt0", 64'(cnt_value), 64'h0);
        check("t1_pwm0", 64'(pwm_out),   64'h0);
        capture(20);
        check("t1_pwm_wave",  pw_bits, 64'h01C07);
        check("t1_tick_wave", ct_bits, 64'h80200);

        // Mid-period shadow update: D=7 written at cnt=2
        cyc();
        cyc();
        cfg_duty = 16'd7;
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        capture(20);
        check("t2_shadow_wave", pw_bits, 64'hE3F80);

        // Load coinciding with the wrap (cnt=9 when load is sampled)
        for (int i = 0; i < 6; i++) cyc();
        check("t3_cnt9", 64'(cnt_value), 64'd9);
        cfg_duty = 16'd2;
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        cfg_duty = 16'd5;
        check("t3_wrap_tick", 64'(cycle_tick), 64'h1);
        capture(15);
        check("t3_wrap_load_wave", pw_bits, 64'h0C03);
        check("t3_cnt5", 64'(cnt_value), 64'd5);

        // Reset mid-run at cnt=5; polarity raised so a missed reset shows
        ARESETN      = 1'b0;
        cfg_polarity = 1'b1;
        cfg_enable   = 1'b0;
        cyc();
        check("t4_rst_pwm",  64'(pwm_out),    64'h0);
        check("t4_rst_tick", 64'(cycle_tick), 64'h0);
        check("t4_rst_busy", 64'(busy),       64'h0);
        check("t4_rst_cnt",  64'(cnt_value),  64'h0);
        ARESETN = 1'b1;
        cyc();
        check("t4_idle_pwm",  64'(pwm_out), 64'h1);
        check("t4_idle_busy", 64'(busy),    64'h0);

        // Prescaler S=3 P=4 D=2
        start(3, 4, 2, 1'b0);
        capture(40);
        check("t5_pre_wave", pw_bits, 64'h0FF000FF);
        check("t5_pre_tick", ct_bits, 64'h8000080000);
        check("t5_cnt_k3",  64'(cnt_log[2]),  64'd0);
        check("t5_cnt_k4",  64'(cnt_log[3]),  64'd1);
        check("t5_cnt_k8",  64'(cnt_log[7]),  64'd2);
        check("t5_cnt_k19", 64'(cnt_log[18]), 64'd4);
        check("t5_cnt_k20", 64'(cnt_log[19]), 64'd0);

        // Duty boundaries and polarity
        start(0, 9, 0, 1'b0);
        capture(20);
        check("t6_duty0", pw_bits, 64'h0);
        start(0, 9, 12, 1'b0);
        capture(20);
        check("t6_duty_full", pw_bits, 64'hFFFFF);
        start(0, 9, 3, 1'b1);
        check("t6_pol_idle", 64'(pwm_out), 64'h1);
        capture(20);
        check("t6_pol_wave", pw_bits, 64'hFE3F8);
        start(0, 0, 1, 1'b0);
        capture(8);
        check("t6_p0_pwm",  pw_bits, 64'hFF);
        check("t6_p0_tick", ct_bits, 64'hFF);

        // Stop at cnt=4: drain to the wrap, then idle
        start(0, 9, 3, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        check("t7_cnt4", 64'(cnt_value), 64'd4);
        cfg_enable = 1'b0;
        cyc();
        check("t7_drain_busy", 64'(busy), 64'h1);
        capture(8);
        check("t7_busy_wave", bz_bits, 64'h0F);
        check("t7_tick_wave", ct_bits, 64'h10);
        check("t7_pwm_wave",  pw_bits, 64'h0);
        check("t7_idle_cnt",  64'(cnt_value), 64'h0);

        // Re-enable during DRAIN: waveform continues unbroken
        start(0, 9, 3, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        cfg_enable = 1'b0;
        cyc();
        cfg_enable = 1'b1;
        cyc();
        capture(14);
        check("t8_pwm_wave",  pw_bits, 64'h70);
        check("t8_busy_wave", bz_bits, 64'h3FFF);
        check("t8_tick_wave", ct_bits, 64'h2008);

`ifdef PWM_DEADTIME_EN
        // Dead time 2, P=9, D=5
        cfg_deadtime = 8'd2;
        start(0, 9, 5, 1'b0);
        capture(20);
        check("t9_dt_pwm",     pw_bits, 64'h701C);
        check("t9_dt_pwm_n",   pn_bits, 64'hE0380);
        check("t9_dt_overlap", pw_bits & pn_bits, 64'h0);
        cfg_deadtime = 8'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
